// File: rtl/switch_out_arbiter.sv
// -----------------------------------------------------------------------------
// switch_out_arbiter
//   Round-robin arbiter and read sequencer for one egress port of the switch.
//   It watches the head-of-line header of every ingress FIFO, picks one whose
//   head packet targets PORT_ID, pops it with a single-cycle rd_en, captures the
//   FIFO's registered data_out and offers the packet on a valid/ready egress.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   fifo_empty    per-FIFO empty flag
//   fifo_header   per-FIFO head header, slice i = [8*i+7:8*i] = {source, target}
//   fifo_data     per-FIFO data_out, valid the cycle after its rd_en
//   fifo_rd_en    per-FIFO pop strobe, at most one bit high
//   out_valid     egress packet valid
//   out_data      egress packet
//   out_ready     egress accepts the packet
//   busy          high whenever the sequencer is not idle
//   grant_id      FIFO currently or last granted
//   pkt_count     packets delivered, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module switch_out_arbiter #(
   parameter int PKT_SIZE  = 16,
   parameter int NUM_PORTS = 4,
   parameter int PORT_ID   = 0,
   parameter int CNT_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          fifo_empty,
   input  logic [NUM_PORTS*8-1:0]        fifo_header,
   input  logic [NUM_PORTS*PKT_SIZE-1:0] fifo_data,
   output logic [NUM_PORTS-1:0]          fifo_rd_en,
   output logic                          out_valid,
   output logic [PKT_SIZE-1:0]           out_data,
   input  logic                          out_ready,
   output logic                          busy,
   output logic [1:0]                    grant_id,
   output logic [CNT_W-1:0]              pkt_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND
   } state_t;

   localparam logic [3:0] PORT_TGT = 4'(PORT_ID);

   state_t                r_state;
   state_t                w_next_state;
   logic [1:0]            r_rr_ptr;
   logic [1:0]            r_grant_id;
   logic [PKT_SIZE-1:0]   r_out_data;
   logic [CNT_W-1:0]      r_pkt_count;

   logic [NUM_PORTS-1:0]  w_req;
   logic                  w_any_req;
   logic [1:0]            w_winner;
   logic                  w_unused_hdr;

   // Source nibbles of the headers are not needed for arbitration.
   assign w_unused_hdr = ^fifo_header;

   // A FIFO requests this port when it holds a packet whose target is PORT_ID.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_req[i] = !fifo_empty[i] && (fifo_header[8*i +: 4] == PORT_TGT);
      end
   end

   // Round-robin search starting at r_rr_ptr. Walking the offsets from the
   // highest down lets the lowest offset with a request overwrite the others,
   // so the first requester at or after the pointer wins.
   always_comb begin
      w_any_req = 1'b0;
      w_winner  = 2'd0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (w_req[(int'(r_rr_ptr) + k) % NUM_PORTS]) begin
            w_any_req = 1'b1;
            w_winner  = 2'((int'(r_rr_ptr) + k) % NUM_PORTS);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every output of this block gets a default first, otherwise a path
   // that skips an assignment would infer a latch.
   always_comb begin
      w_next_state = r_state;
      fifo_rd_en   = '0;
      case (r_state)
         S_IDLE: if (w_any_req) w_next_state = S_READ;
         S_READ: begin
            // Pop strobe comes from registered state, never from w_req, so a
            // header change after the pop cannot cause a second pop.
            fifo_rd_en[r_grant_id] = 1'b1;
            w_next_state           = S_WAIT;
         end
         S_WAIT: w_next_state = S_SEND;
         S_SEND: if (out_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= 2'd0;
         r_grant_id  <= 2'd0;
         r_out_data  <= '0;
         r_pkt_count <= '0;
      end else begin
         if (r_state == S_IDLE && w_any_req) begin
            r_grant_id <= w_winner;
         end
         // FIFO data_out became valid at the edge that ended READ.
         if (r_state == S_WAIT) begin
            r_out_data <= fifo_data[PKT_SIZE*int'(r_grant_id) +: PKT_SIZE];
         end
         // The pointer only moves past a grant once its packet is delivered.
         if (r_state == S_SEND && out_ready) begin
            r_pkt_count <= r_pkt_count + 1'b1;
            r_rr_ptr    <= 2'((int'(r_grant_id) + 1) % NUM_PORTS);
         end
      end
   end

   assign out_valid = (r_state == S_SEND);
   assign out_data  = r_out_data;
   assign busy      = (r_state != S_IDLE);
   assign grant_id  = r_grant_id;
   assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_switch_out_arbiter
//   Bench for switch_out_arbiter (PORT_ID=0, CNT_W=4). Four ingress FIFOs are
//   modelled with registered data_out. Expected egress packets are queued when
//   they are loaded and compared in order when a handshake is observed.
// -----------------------------------------------------------------------------
module tb_switch_out_arbiter;

   localparam int PKT_SIZE  = 16;
   localparam int NUM_PORTS = 4;
   localparam int CNT_W     = 4;

   logic                          clk;
   logic                          rst_n;
   logic [NUM_PORTS-1:0]          fifo_empty;
   logic [NUM_PORTS*8-1:0]        fifo_header;
   logic [NUM_PORTS*PKT_SIZE-1:0] fifo_data;
   logic [NUM_PORTS-1:0]          fifo_rd_en;
   logic                          out_valid;
   logic [PKT_SIZE-1:0]           out_data;
   logic                          out_ready;
   logic                          busy;
   logic [1:0]                    grant_id;
   logic [CNT_W-1:0]              pkt_count;

   switch_out_arbiter #(
      .PKT_SIZE (PKT_SIZE),
      .NUM_PORTS(NUM_PORTS),
      .PORT_ID  (0),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_header(fifo_header),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .grant_id   (grant_id),
      .pkt_count  (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ingress FIFO model ----------------
   logic [15:0] mem [NUM_PORTS][64];
   int          rd_ptr [NUM_PORTS];
   int          wr_ptr [NUM_PORTS];
   logic [15:0] data_reg [NUM_PORTS];

   initial begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         rd_ptr[i]   = 0;
         wr_ptr[i]   = 0;
         data_reg[i] = '0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (fifo_rd_en[i]) begin
            data_reg[i] <= mem[i][rd_ptr[i] & 63];
            rd_ptr[i]   <= rd_ptr[i] + 1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         fifo_empty[i]                  = (rd_ptr[i] == wr_ptr[i]);
         fifo_header[8*i +: 8]          = mem[i][rd_ptr[i] & 63][15:8];
         fifo_data[PKT_SIZE*i +: PKT_SIZE] = data_reg[i];
      end
   end

   // ---------------- scoreboard and checking ----------------
   typedef struct {
      logic [15:0] data;
      logic [1:0]  src;
   } exp_t;

   exp_t sb[$];
   int   total    = 0;
   int   bad      = 0;
   int   multihot = 0;
   int   rd_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if ($countones(fifo_rd_en) > 1) multihot++;
      if (fifo_rd_en != '0) rd_pulses++;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("grant_id", 32'(grant_id), 32'(e.src));
         end
      end
   end

   task automatic push(input int f, input logic [15:0] pkt, input bit expect_out);
      exp_t e;
      mem[f][wr_ptr[f] & 63] = pkt;
      wr_ptr[f]++;
      if (expect_out) begin
         e.data = pkt;
         e.src  = 2'(f);
         sb.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) wr_ptr[i] = rd_ptr[i];
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   // ---------------- single-packet vector table ----------------
   typedef struct {
      int          fifo;
      logic [15:0] pkt;
      logic [3:0]  exp_rd;
      logic        exp_match;
   } vec_t;

   vec_t vecs [6];

   initial begin
      bit stable;
      int pulses_before;

      vecs[0] = '{2, 16'h205A, 4'b0100, 1'b1};
      vecs[1] = '{0, 16'h0011, 4'b0001, 1'b1};
      vecs[2] = '{3, 16'h3077, 4'b1000, 1'b1};
      vecs[3] = '{1, 16'h1300, 4'b0000, 1'b0};
      vecs[4] = '{1, 16'h1122, 4'b0000, 1'b0};
      vecs[5] = '{3, 16'h32FF, 4'b0000, 1'b0};

      rst_n     = 1'b0;
      out_ready = 1'b0;
      do_reset();

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_rd_en",     32'(fifo_rd_en), 32'd0);
      check("rst_out_data",  32'(out_data), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      check("rst_grant_id",  32'(grant_id), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);

      // Table: one packet from reset, cycle-accurate latency
      foreach (vecs[v]) begin
         do_reset();
         out_ready = 1'b1;
         push(vecs[v].fifo, vecs[v].pkt, vecs[v].exp_match);
         @(negedge clk);
         check("c1_rd_en", 32'(fifo_rd_en), 32'(vecs[v].exp_rd));
         @(negedge clk);
         check("c2_rd_en", 32'(fifo_rd_en), 32'd0);
         check("c2_valid", 32'(out_valid), 32'd0);
         @(negedge clk);
         check("c3_valid", 32'(out_valid), 32'(vecs[v].exp_match));
         check("c3_data",  32'(out_data), vecs[v].exp_match ? 32'(vecs[v].pkt) : 32'd0);
         check("c3_busy",  32'(busy), 32'(vecs[v].exp_match));
         @(negedge clk);
         check("c4_valid", 32'(out_valid), 32'd0);
         check("c4_count", 32'(pkt_count), 32'(vecs[v].exp_match));
      end

      // Fairness: two packets in every FIFO, grant order 0,1,2,3,0,1,2,3
      do_reset();
      out_ready = 1'b1;
      multihot  = 0;
      for (int n = 0; n < 2; n++)
         for (int i = 0; i < NUM_PORTS; i++)
            push(i, {4'(i), 4'h0, 8'(16*i + n)}, 1'b1);
      wait_drain(100);
      check("fair_count", 32'(pkt_count), 32'd8);
      check("fair_multihot", 32'(multihot), 32'd0);

      // Backpressure: stalled in SEND for 10 cycles
      do_reset();
      out_ready = 1'b0;
      push(1, 16'h10AA, 1'b1);
      push(2, 16'h20BB, 1'b1);
      repeat (3) @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      pulses_before = rd_pulses;
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!out_valid || out_data !== 16'h10AA) stable = 1'b0;
      end
      check("bp_stable", 32'(stable), 32'd1);
      check("bp_no_rd", 32'(rd_pulses - pulses_before), 32'd0);
      out_ready = 1'b1;
      wait_drain(30);
      check("bp_count", 32'(pkt_count), 32'd2);

      // Non-matching target is never popped
      do_reset();
      out_ready = 1'b1;
      pulses_before = rd_pulses;
      push(1, 16'h1300, 1'b0);
      repeat (5) @(negedge clk);
      check("nm_busy", 32'(busy), 32'd0);
      check("nm_no_rd", 32'(rd_pulses - pulses_before), 32'd0);
      push(3, 16'h30CC, 1'b1);
      wait_drain(20);
      check("nm_fifo1_left", 32'(wr_ptr[1] - rd_ptr[1]), 32'd1);
      check("nm_count", 32'(pkt_count), 32'd1);

      // Reset during WAIT aborts, arbitration restarts at index 0
      do_reset();
      out_ready = 1'b1;
      push(0, 16'h0001, 1'b1);
      wait_drain(20);
      check("mr_count_pre", 32'(pkt_count), 32'd1);
      push(2, 16'h2022, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("mr_in_wait", 32'(busy && !out_valid && fifo_rd_en == '0), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_rd_en", 32'(fifo_rd_en), 32'd0);
      check("mr_count", 32'(pkt_count), 32'd0);
      check("mr_busy",  32'(busy), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push(3, 16'h3044, 1'b0);
      push(0, 16'h0055, 1'b1);
      begin
         exp_t e;
         e.data = 16'h3044;
         e.src  = 2'd3;
         sb.push_back(e);
      end
      wait_drain(30);
      check("mr_count_post", 32'(pkt_count), 32'd2);

      // Counter wrap: 17 deliveries with a 4-bit counter
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++)
         push(k % 4, {4'(k % 4), 4'h0, 8'(k)}, 1'b1);
      wait_drain(150);
      check("wrap_count", 32'(pkt_count), 32'd1);
      check("final_multihot", 32'(multihot), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_out_arbiter.md
Name: switch_out_arbiter

Overview:
- One instance per egress port of the 4-port switch. Round-robin arbiter and read sequencer for that port.
- Watches the head-of-line header of every ingress FIFO and selects one FIFO whose head packet targets this port.
- Pops the selected FIFO with a single-cycle rd_en, captures the registered FIFO output, and presents the packet to the egress with a valid/ready handshake.

Parameters:
- PKT_SIZE, 16, packet width: source[15:12], target[11:8], data[7:0].
- NUM_PORTS, 4, number of ingress FIFOs / requesters.
- PORT_ID, 0, index of the egress port this instance serves (0..NUM_PORTS-1).
- CNT_W, 16, width of the delivered-packet counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  NUM_PORTS  per-FIFO empty flag.
- fifo_header  input  NUM_PORTS*8  per-FIFO head header; slice i = [8*i+7:8*i], with [7:4] = source and [3:0] = target.
- fifo_data  input  NUM_PORTS*PKT_SIZE  per-FIFO data_out, registered one cycle after rd_en; slice i = [PKT_SIZE*i +: PKT_SIZE].
- fifo_rd_en  output  NUM_PORTS  per-FIFO pop strobe; at most one bit high at a time.
- out_valid  output  1  egress packet valid.
- out_data  output  PKT_SIZE  egress packet.
- out_ready  input  1  egress accepts the packet.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  2  index of the FIFO currently or last granted.
- pkt_count  output  CNT_W  count of packets delivered (accepted handshakes).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, grant_id=0, fifo_rd_en=0, out_valid=0, out_data=0, pkt_count=0.
  - Reset asserted mid-transfer aborts the transfer. A packet already popped is lost; this is accepted.
- Request: req[i] = !fifo_empty[i] && (fifo_header[i][3:0] == PORT_ID). Target values >= NUM_PORTS match no port; upstream guarantees legal targets.
- Round-robin selection: search from index rr_ptr upward, modulo NUM_PORTS. The first i with req[i] high wins.
- FSM states and transitions:
  - IDLE: if any req is high, latch the winner into grant_id and go to READ; otherwise stay in IDLE.
  - READ: fifo_rd_en[grant_id]=1 for exactly this one cycle (driven from registered state, not from req). Go to WAIT.
  - WAIT: the FIFO's data_out updates at the edge ending READ. Capture fifo_data slice grant_id into out_data, set out_valid=1, go to SEND.
  - SEND: out_valid=1 and out_data held stable.
    - out_ready=1: handshake completes. out_valid=0 next cycle, pkt_count+1 (wraps at 2^CNT_W), rr_ptr=(grant_id+1) mod NUM_PORTS, go to IDLE.
    - out_ready=0: stay in SEND. No other FIFO is popped while stalled.
- Latency: req high in cycle 0 (IDLE) -> rd_en in cycle 1 -> out_valid in cycle 3. Minimum 4 cycles per packet including the IDLE re-arbitration cycle.
- Arbiter does not read fifo_empty or header during READ/WAIT/SEND, so the pointer update after a pop causes no double pop.
- Multiple instances: a FIFO head targets exactly one port, so no two instances pop the same FIFO in the same cycle. The switch ORs fifo_rd_en across instances.
- rr_ptr changes only on a completed handshake. If a requester drops its request before being granted, nothing changes.
- out_ready is ignored when out_valid=0.

Test Plan:
- Single packet: FIFO2 holds 0x2_0_5A (source 2, target 0, data 0x5A), PORT_ID=0, out_ready=1 -> fifo_rd_en=4'b0100 in cycle 1 only; out_valid and out_data=0x205A in cycle 3; pkt_count=1.
- Fairness: FIFOs 0..3 each hold 2 packets targeting port 0, out_ready=1 -> grant order 0,1,2,3,0,1,2,3; pkt_count=8; fifo_rd_en never multi-hot.
- Backpressure: out_ready=0 for 10 cycles while in SEND -> out_valid and out_data stable, no further rd_en; ready high -> handshake, then next grant.
- Non-matching target: FIFO1 head target=3, PORT_ID=0 -> no rd_en, busy=0; FIFO3 then gets target 0 -> granted, FIFO1 untouched.
- Reset mid-operation: rst_n low during WAIT -> next sample shows out_valid=0, fifo_rd_en=0, pkt_count=0, state IDLE; after release, arbitration restarts at index 0.
- Counter wrap: preload traffic with CNT_W=4 and deliver 17 packets -> pkt_count=1.
